// File: rtl/morse_letter_decoder.sv
// Turns a stream of dit/dah/gap/space symbol codes into ASCII characters.
// Letters and digits come out on the edge that samples the terminating GAP or SPACE.
module morse_letter_decoder #(
  parameter logic [7:0] ERR_CHAR           = 8'h3F,
  parameter bit         DUP_SPACE_SUPPRESS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ditsdahs,
  output logic [7:0] char,
  output logic       char_valid,
  output logic       char_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_OVERFLOW,
    S_SPACE_PEND
  } state_t;

  localparam logic [2:0] CODE_WAIT  = 3'd0;
  localparam logic [2:0] CODE_DIT   = 3'd1;
  localparam logic [2:0] CODE_DAH   = 3'd2;
  localparam logic [2:0] CODE_GAP   = 3'd3;
  localparam logic [2:0] CODE_SPACE = 3'd4;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  state_t     r_state, w_stateNext;
  logic [2:0] r_prev;
  logic [2:0] r_len, w_lenNext;
  logic [4:0] r_pattern, w_patternNext;
  logic       r_lastSpace, w_lastSpaceNext;
  logic [7:0] r_char, w_charNext;
  logic       r_valid, w_validNext;
  logic       r_err, w_errNext;

  logic       w_accept;
  logic       w_isSym;
  logic       w_isGap;
  logic       w_isSpace;
  logic       w_symBit;
  logic [7:0] w_lookChar;
  logic       w_lookOk;
  logic [7:0] w_grpChar;
  logic       w_grpErr;

  // Only a change to a real symbol code counts; held codes and codes 5-7 do not.
  assign w_accept  = (ditsdahs != CODE_WAIT) && (ditsdahs <= CODE_SPACE) && (ditsdahs != r_prev);
  assign w_isSym   = w_accept && ((ditsdahs == CODE_DIT) || (ditsdahs == CODE_DAH));
  assign w_isGap   = w_accept && (ditsdahs == CODE_GAP);
  assign w_isSpace = w_accept && (ditsdahs == CODE_SPACE);
  assign w_symBit  = (ditsdahs == CODE_DAH);

  // Upper pattern bits above len stay zero, so {len, pattern} is a unique key.
  always_comb begin
    w_lookOk   = 1'b1;
    w_lookChar = ERR_CHAR;
    case ({r_len, r_pattern})
      {3'd2, 5'b00001}: w_lookChar = 8'h41;
      {3'd4, 5'b01000}: w_lookChar = 8'h42;
      {3'd4, 5'b01010}: w_lookChar = 8'h43;
      {3'd3, 5'b00100}: w_lookChar = 8'h44;
      {3'd1, 5'b00000}: w_lookChar = 8'h45;
      {3'd4, 5'b00010}: w_lookChar = 8'h46;
      {3'd3, 5'b00110}: w_lookChar = 8'h47;
      {3'd4, 5'b00000}: w_lookChar = 8'h48;
      {3'd2, 5'b00000}: w_lookChar = 8'h49;
      {3'd4, 5'b00111}: w_lookChar = 8'h4A;
      {3'd3, 5'b00101}: w_lookChar = 8'h4B;
      {3'd4, 5'b00100}: w_lookChar = 8'h4C;
      {3'd2, 5'b00011}: w_lookChar = 8'h4D;
      {3'd2, 5'b00010}: w_lookChar = 8'h4E;
      {3'd3, 5'b00111}: w_lookChar = 8'h4F;
      {3'd4, 5'b00110}: w_lookChar = 8'h50;
      {3'd4, 5'b01101}: w_lookChar = 8'h51;
      {3'd3, 5'b00010}: w_lookChar = 8'h52;
      {3'd3, 5'b00000}: w_lookChar = 8'h53;
      {3'd1, 5'b00001}: w_lookChar = 8'h54;
      {3'd3, 5'b00001}: w_lookChar = 8'h55;
      {3'd4, 5'b00001}: w_lookChar = 8'h56;
      {3'd3, 5'b00011}: w_lookChar = 8'h57;
      {3'd4, 5'b01001}: w_lookChar = 8'h58;
      {3'd4, 5'b01011}: w_lookChar = 8'h59;
      {3'd4, 5'b01100}: w_lookChar = 8'h5A;
      {3'd5, 5'b11111}: w_lookChar = 8'h30;
      {3'd5, 5'b01111}: w_lookChar = 8'h31;
      {3'd5, 5'b00111}: w_lookChar = 8'h32;
      {3'd5, 5'b00011}: w_lookChar = 8'h33;
      {3'd5, 5'b00001}: w_lookChar = 8'h34;
      {3'd5, 5'b00000}: w_lookChar = 8'h35;
      {3'd5, 5'b10000}: w_lookChar = 8'h36;
      {3'd5, 5'b11000}: w_lookChar = 8'h37;
      {3'd5, 5'b11100}: w_lookChar = 8'h38;
      {3'd5, 5'b11110}: w_lookChar = 8'h39;
      default:          w_lookOk   = 1'b0;
    endcase
  end

  assign w_grpErr  = (r_state == S_OVERFLOW) || !w_lookOk;
  assign w_grpChar = w_grpErr ? ERR_CHAR : w_lookChar;

  always_comb begin
    w_stateNext     = r_state;
    w_lenNext       = r_len;
    w_patternNext   = r_pattern;
    w_lastSpaceNext = r_lastSpace;
    w_charNext      = r_char;
    w_validNext     = 1'b0;
    w_errNext       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_isSym) begin
          w_stateNext   = S_COLLECT;
          w_lenNext     = 3'd1;
          w_patternNext = {4'b0000, w_symBit};
        end else if (w_isSpace && !(DUP_SPACE_SUPPRESS && r_lastSpace)) begin
          w_charNext      = ASCII_SPACE;
          w_validNext     = 1'b1;
          w_lastSpaceNext = 1'b1;
        end
      end
      S_COLLECT, S_OVERFLOW: begin
        if (w_isSym) begin
          // The sixth symbol freezes the pattern; the group can only end in error now.
          if ((r_state == S_OVERFLOW) || (r_len == 3'd5)) begin
            w_stateNext = S_OVERFLOW;
          end else begin
            w_lenNext     = r_len + 3'd1;
            w_patternNext = {r_pattern[3:0], w_symBit};
          end
        end else if (w_isGap || w_isSpace) begin
          w_charNext      = w_grpChar;
          w_validNext     = 1'b1;
          w_errNext       = w_grpErr;
          w_lastSpaceNext = 1'b0;
          w_lenNext       = 3'd0;
          w_patternNext   = 5'd0;
          w_stateNext     = w_isSpace ? S_SPACE_PEND : S_IDLE;
        end
      end
      S_SPACE_PEND: begin
        w_charNext      = ASCII_SPACE;
        w_validNext     = 1'b1;
        w_lastSpaceNext = 1'b1;
        w_stateNext     = S_IDLE;
        w_lenNext       = 3'd0;
        w_patternNext   = 5'd0;
        if (w_isSym) begin
          w_stateNext   = S_COLLECT;
          w_lenNext     = 3'd1;
          w_patternNext = {4'b0000, w_symBit};
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prev      <= CODE_WAIT;
      r_len       <= 3'd0;
      r_pattern   <= 5'd0;
      r_lastSpace <= 1'b0;
      r_char      <= 8'h00;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_prev      <= ditsdahs;
      r_len       <= w_lenNext;
      r_pattern   <= w_patternNext;
      r_lastSpace <= w_lastSpaceNext;
      r_char      <= w_charNext;
      r_valid     <= w_validNext;
      r_err       <= w_errNext;
    end
  end

  assign char       = r_char;
  assign char_valid = r_valid;
  assign char_err   = r_err;

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Drives directed and random symbol streams and compares every cycle against
// a string-based Morse model.
module tb_morse_letter_decoder;

  localparam logic [7:0] ERR = 8'h3F;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ditsdahs;
  logic [7:0] char;
  logic       char_valid;
  logic       char_err;

  morse_letter_decoder #(
    .ERR_CHAR(ERR),
    .DUP_SPACE_SUPPRESS(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ditsdahs(ditsdahs),
    .char(char),
    .char_valid(char_valid),
    .char_err(char_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  string phase = "init";

  string mCode[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----."};

  string      mSym;
  bit         mOvf;
  bit         mPendSpace;
  bit         mLastSpace;
  logic [2:0] mPrev;
  logic [7:0] mChar;
  bit         mValid;
  bit         mErr;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s/%s: observed %h expected %h at %0t", phase, tag, observed, expected, $time);
    end
  endtask

  function automatic int findCode(string s);
    for (int i = 0; i < 36; i++) if (mCode[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [7:0] charOf(int idx);
    if (idx < 26) return 8'(65 + idx);
    return 8'(48 + idx - 26);
  endfunction

  function automatic void modelEmit(logic [7:0] c, bit e);
    mValid     = 1'b1;
    mChar      = c;
    mErr       = e;
    mLastSpace = (c == 8'h20);
  endfunction

  // Predicts what the decoder shows after the edge that samples this code.
  function automatic void modelStep(logic [2:0] code, bit rst);
    bit    acc;
    int    idx;
    string d;
    mValid = 1'b0;
    mErr   = 1'b0;
    if (rst) begin
      mSym = ""; mOvf = 0; mPendSpace = 0; mLastSpace = 0; mPrev = 3'd0; mChar = 8'h00;
      return;
    end
    acc   = (code inside {3'd1, 3'd2, 3'd3, 3'd4}) && (code != mPrev);
    mPrev = code;
    if (code == 3'd1) d = "."; else d = "-";
    if (mPendSpace) begin
      mPendSpace = 0;
      modelEmit(8'h20, 1'b0);
      if (acc && (code inside {3'd1, 3'd2})) mSym = d;
      return;
    end
    if (!acc) return;
    if (code inside {3'd1, 3'd2}) begin
      if (mSym.len() < 5) mSym = {mSym, d};
      else mOvf = 1;
    end else if (mSym.len() == 0) begin
      if (code == 3'd4 && !mLastSpace) modelEmit(8'h20, 1'b0);
    end else begin
      idx = mOvf ? -1 : findCode(mSym);
      if (idx < 0) modelEmit(ERR, 1'b1);
      else modelEmit(charOf(idx), 1'b0);
      mSym = "";
      mOvf = 0;
      if (code == 3'd4) mPendSpace = 1;
    end
  endfunction

  task automatic applyStimulus(input logic [2:0] code, input bit rst = 1'b0);
    ditsdahs = code;
    reset    = rst;
    modelStep(code, rst);
    @(posedge clk);
    #1;
    checkOutput("char_valid", {7'b0, char_valid}, {7'b0, mValid});
    checkOutput("char_err", {7'b0, char_err}, {7'b0, mErr});
    checkOutput("char", char, mChar);
  endtask

  task automatic sendSymbols(input string s, input logic [2:0] term, input int hold);
    logic [2:0] sc;
    for (int i = 0; i < s.len(); i++) begin
      sc = (s[i] == 8'h2E) ? 3'd1 : 3'd2;
      repeat (hold) applyStimulus(sc);
      applyStimulus(3'd0);
    end
    applyStimulus(term);
    applyStimulus(3'd0);
  endtask

  initial begin
    string rs;
    int    r;
    reset    = 1'b1;
    ditsdahs = 3'd0;

    phase = "reset";
    applyStimulus(3'd0, 1'b1);
    applyStimulus(3'd2, 1'b1);
    checkOutput("resetChar", char, 8'h00);

    phase = "letterA";
    sendSymbols(".-", 3'd3, 1);
    checkOutput("heldA", char, 8'h41);

    phase = "digit0";
    sendSymbols("-----", 3'd3, 1);
    checkOutput("held0", char, 8'h30);

    phase = "heldDitI";
    applyStimulus(3'd1); applyStimulus(3'd1); applyStimulus(3'd1);
    applyStimulus(3'd0); applyStimulus(3'd1); applyStimulus(3'd3);
    checkOutput("charI", char, 8'h49);
    applyStimulus(3'd0);

    phase = "overflow";
    sendSymbols("......", 3'd3, 1);
    checkOutput("ovfChar", char, ERR);
    sendSymbols(".", 3'd3, 1);
    checkOutput("afterOvfE", char, 8'h45);

    phase = "space";
    applyStimulus(3'd1); applyStimulus(3'd4);
    checkOutput("spaceLetter", char, 8'h45);
    applyStimulus(3'd0);
    checkOutput("trailSpace", char, 8'h20);
    applyStimulus(3'd4);
    checkOutput("dupSpace", {7'b0, char_valid}, 8'h00);
    applyStimulus(3'd0);

    phase = "midReset";
    applyStimulus(3'd2); applyStimulus(3'd1);
    applyStimulus(3'd0, 1'b1);
    applyStimulus(3'd2); applyStimulus(3'd3);
    checkOutput("charT", char, 8'h54);
    applyStimulus(3'd0);

    phase = "ignored";
    applyStimulus(3'd3); applyStimulus(3'd6); applyStimulus(3'd0);
    applyStimulus(3'd6); applyStimulus(3'd1); applyStimulus(3'd6);
    applyStimulus(3'd1); applyStimulus(3'd7); applyStimulus(3'd3);
    applyStimulus(3'd0);

    phase = "random";
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        applyStimulus(3'($urandom_range(0, 7)), 1'b1);
      end else if (r < 22) begin
        sendSymbols(mCode[$urandom_range(0, 35)], ($urandom_range(0, 2) == 0) ? 3'd4 : 3'd3,
                    $urandom_range(1, 2));
      end else if (r < 28) begin
        rs = "";
        for (int k = 0; k < $urandom_range(1, 7); k++) rs = {rs, ($urandom_range(0, 1) == 0) ? "." : "-"};
        sendSymbols(rs, ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd3, 1);
      end else begin
        repeat ($urandom_range(1, 3)) applyStimulus(3'($urandom_range(0, 7)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_letter_decoder.md
MORSE_LETTER_DECODER -- requirements
Module: morse_letter_decoder

Interface
REQ-001 SHALL have parameter ERR_CHAR, default 8'h3F, the ASCII code emitted for invalid or overflowed symbol groups.
REQ-002 SHALL have parameter DUP_SPACE_SUPPRESS, default 1; when set, the block never emits consecutive space characters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ditsdahs, input, 3 bits: upstream symbol code, 0 WAIT, 1 DIT, 2 DAH, 3 GAP, 4 SPACE.
REQ-006 SHALL have port char, output, 8 bits: the ASCII character, held until the next emission.
REQ-007 SHALL have port char_valid, output, 1 bit: a one-cycle pulse marking a new char.
REQ-008 SHALL have port char_err, output, 1 bit: high with char_valid when char equals ERR_CHAR because of a decode failure.

Function
REQ-009 SHALL sample ditsdahs every rising edge and register the previous sample; an event is accepted only when the sample is not WAIT and differs from the previous sample.
- A code held for several cycles counts as one event.
REQ-010 SHALL ignore codes 5-7 entirely; they are not events, and the previous-sample register is still updated.
REQ-011 SHALL keep a 5-bit pattern register (DIT=0, DAH=1; each new symbol shifts in at the LSB) and a 3-bit length counter (0..5).
REQ-012 SHALL use a state machine with states IDLE (len=0), COLLECT (1..5 symbols), OVERFLOW (more than 5 symbols seen) and SPACE_PEND.
REQ-013 SHALL handle an accepted DIT/DAH as follows:
- IDLE -> COLLECT with len=1.
- COLLECT with len<5: increment len.
- COLLECT with len=5: go to OVERFLOW; the pattern is frozen.
- OVERFLOW: stay in OVERFLOW.
REQ-014 SHALL, on an accepted GAP in COLLECT, look up {len, pattern}, drive char and char_valid=1 on that same edge, and return to IDLE.
- Lookup covers A-Z (0x41-0x5A) and 0-9 (0x30-0x39) per ITU Morse.
- A pattern with no entry gives char=ERR_CHAR and char_err=1.
REQ-015 SHALL, on an accepted GAP in OVERFLOW, emit ERR_CHAR with char_err=1 and return to IDLE.
REQ-016 SHALL, on an accepted GAP in IDLE, emit nothing.
REQ-017 SHALL, on an accepted SPACE in COLLECT or OVERFLOW, emit the pending letter (or ERR_CHAR) on that edge, enter SPACE_PEND, and emit 0x20 on the next edge.
REQ-018 SHALL, on an accepted SPACE in IDLE, emit 0x20 on that edge, unless DUP_SPACE_SUPPRESS=1 and the last emitted char was 0x20.
REQ-019 SHALL go from SPACE_PEND to IDLE unconditionally after one cycle.
- A DIT/DAH accepted on that same edge starts a new group (len=1) in COLLECT.
- A GAP or SPACE accepted on that edge is dropped.
REQ-020 SHALL drive char_valid for exactly one cycle per emission and deassert char_err whenever char_valid is low.
REQ-021 SHALL have a latency of zero cycles from the sampling edge of a terminating event to the char_valid edge, plus one cycle for the trailing space.

Reset
REQ-022 SHALL, on any edge with reset=1, clear:
- char=0, char_valid=0, char_err=0.
- len=0, pattern=0, state IDLE.
- previous sample = WAIT.
- The last-emitted-space flag.
REQ-023 SHALL discard a partially collected group on reset, emitting no output for it.
REQ-024 SHALL give reset priority over any simultaneous event.

Verification
REQ-025 SHALL pass: DIT, WAIT, DAH, WAIT, GAP -> char=0x41, char_valid high one cycle, char_err=0.
REQ-026 SHALL pass: DAH, WAIT between each, repeated 5 times, then GAP -> 0x30; DIT held 3 cycles, WAIT, DIT, GAP -> 0x49 ('I').
REQ-027 SHALL pass: 6 DITs separated by WAIT, then GAP -> char=0x3F, char_err=1; the next DIT, GAP -> 0x45.
REQ-028 SHALL pass: DIT, SPACE -> 0x45 on the SPACE edge, 0x20 on the next edge; WAIT, SPACE again -> no output (DUP_SPACE_SUPPRESS=1).
REQ-029 SHALL pass: DAH, DIT, then reset one cycle, then DAH, GAP -> only 0x54 ('T') emitted.
REQ-030 SHALL pass: GAP in IDLE, and code 6 at any time -> no char_valid and no state change.
